mem_byte_access: RTL and testbench

//  Load/store access unit placed directly upstream of the dual-port data RAM.

---
 rtl/mem_byte_access.sv | 155 +++++++++++++++
 tb/tb_mem_byte_access.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_access.sv
// Load/store unit in front of a dual-port data RAM: byte/half/word accesses become
// serialised word reads and writes, with read-modify-write for sub-word stores.
module mem_byte_access #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [1:0]    size_i,
  input  logic          unsigned_i,
  input  logic [AW+1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          ready_o,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic          wdone_o,
  output logic          err_o,
  output logic          ram_ren_o,
  output logic [AW-1:0] ram_raddr_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          ram_wen_o,
  output logic [AW-1:0] ram_waddr_o,
  output logic [DW-1:0] ram_wdata_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_LD_RESP = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_MERGE   = 3'd4;

  logic [2:0]    r_state;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [AW+1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic          r_wdone;
  logic          r_err;

  logic          w_accept;
  logic          w_bad;
  logic [3:0]    w_be;
  logic [DW-1:0] w_wrep;
  logic [DW-1:0] w_merged;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [DW-1:0] w_ld_ext;

  assign w_accept = req_i && (r_state == S_IDLE);
  assign w_bad    = (size_i == 2'b11) ||
                    (size_i == 2'b01 && addr_i[0]) ||
                    (size_i == 2'b10 && addr_i[1:0] != 2'b00);

  // Lane enables and store data replicated across every lane it could land in
  always_comb begin
    w_be   = 4'hF;
    w_wrep = r_wdata;
    case (r_size)
      2'b00: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_wrep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'hF;
        w_wrep = r_wdata;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged[8*gi +: 8] = w_be[gi] ? w_wrep[8*gi +: 8] : ram_rdata_i[8*gi +: 8];
    end
  endgenerate

  assign w_byte = ram_rdata_i[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];

  always_comb begin
    case (r_size)
      2'b00:   w_ld_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ld_ext = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_ld_ext = ram_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_uns    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_wdone  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_wdone  <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= we_i;
            r_size  <= size_i;
            r_uns   <= unsigned_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            if (w_bad)
              r_err <= 1'b1;
            else if (we_i && size_i == 2'b10)
              r_state <= S_WR;
            else
              r_state <= S_RD;
          end
        end
        S_RD:      r_state <= r_we ? S_MERGE : S_LD_RESP;
        S_LD_RESP: begin
          r_rdata  <= w_ld_ext;
          r_rvalid <= 1'b1;
          r_state  <= S_IDLE;
        end
        S_WR, S_MERGE: begin
          r_wdone <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = rst && (r_state == S_IDLE);
  assign rvalid_o    = r_rvalid;
  assign rdata_o     = r_rdata;
  assign wdone_o     = r_wdone;
  assign err_o       = r_err;
  assign ram_ren_o   = (r_state == S_RD);
  assign ram_raddr_o = r_addr[AW+1:2];
  assign ram_wen_o   = (r_state == S_WR) || (r_state == S_MERGE);
  assign ram_waddr_o = r_addr[AW+1:2];
  assign ram_wdata_o = (r_state == S_WR)    ? r_wdata  :
                       (r_state == S_MERGE) ? w_merged : '0;

endmodule

// File: tb/tb_mem_byte_access.sv
// Scoreboard bench for mem_byte_access: expected RAM traffic, pulses and load data
// are queued with their due cycle when a request is issued and matched on output.
module tb_mem_byte_access;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [1:0]    size_i = 2'b00;
  logic          unsigned_i = 1'b0;
  logic [AW+1:0] addr_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic          ready_o, rvalid_o, wdone_o, err_o, ram_ren_o, ram_wen_o;
  logic [DW-1:0] rdata_o, ram_wdata_o;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_raddr_o, ram_waddr_o;

  always #5 clk = ~clk;

  mem_byte_access #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ready_o(ready_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .wdone_o(wdone_o), .err_o(err_o),
    .ram_ren_o(ram_ren_o), .ram_raddr_o(ram_raddr_o), .ram_rdata_i(ram_rdata),
    .ram_wen_o(ram_wen_o), .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o)
  );

  // Behavioural RAM with a bench-side preload port
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (ram_wen_o) mem[ram_waddr_o] <= ram_wdata_o;
    else if (pl_en) mem[pl_addr] <= pl_data;
    if (ram_ren_o) ram_rdata <= mem[ram_raddr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] addr;
    int            due;
  } sb_t;
  sb_t q_rd[$], q_ren[$], q_wr[$], q_wd[$], q_err[$];

  logic [31:0] model [0:(1<<AW)-1];

  function automatic sb_t mk(input logic [31:0] d, input logic [AW-1:0] a, input int due);
    sb_t e;
    e.data = d; e.addr = a; e.due = due;
    return e;
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] sz,
                                         input logic uns, input logic [AW+1:0] a);
    logic [31:0] s;
    case (sz)
      2'b00: begin
        s = w >> (8 * int'(a[1:0]));
        return uns ? (s & 32'h0000_00FF) : {{24{s[7]}}, s[7:0]};
      end
      2'b01: begin
        s = w >> (16 * int'(a[1]));
        return uns ? (s & 32'h0000_FFFF) : {{16{s[15]}}, s[15:0]};
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [1:0] sz,
                                           input logic [AW+1:0] a, input logic [31:0] wd);
    int sh;
    logic [31:0] m;
    case (sz)
      2'b00: begin sh = 8 * int'(a[1:0]); m = 32'h0000_00FF << sh; end
      2'b01: begin sh = 16 * int'(a[1]);  m = 32'h0000_FFFF << sh; end
      default: return wd;
    endcase
    return (old & ~m) | ((wd << sh) & m);
  endfunction

  // Output monitor: every pulse must match the head of its queue, on its due cycle
  always @(negedge clk) begin
    sb_t e;
    if (ram_ren_o || ram_wen_o) check("ren_wen_excl", {31'b0, ram_ren_o & ram_wen_o}, 32'd0);
    if (ram_ren_o) begin
      if (q_ren.size() == 0) check("ren_unexpected", {31'b0, ram_ren_o}, 32'd0);
      else begin
        e = q_ren.pop_front();
        check("ren_addr", {20'b0, ram_raddr_o}, {20'b0, e.addr});
        check("ren_cycle", cyc, e.due);
      end
    end
    if (ram_wen_o) begin
      if (q_wr.size() == 0) check("wen_unexpected", {31'b0, ram_wen_o}, 32'd0);
      else begin
        e = q_wr.pop_front();
        check("wen_addr", {20'b0, ram_waddr_o}, {20'b0, e.addr});
        check("wen_data", ram_wdata_o, e.data);
        check("wen_cycle", cyc, e.due);
      end
    end
    if (rvalid_o) begin
      if (q_rd.size() == 0) check("rvalid_unexpected", {31'b0, rvalid_o}, 32'd0);
      else begin
        e = q_rd.pop_front();
        check("rdata", rdata_o, e.data);
        check("rvalid_cycle", cyc, e.due);
      end
    end
    if (wdone_o) begin
      if (q_wd.size() == 0) check("wdone_unexpected", {31'b0, wdone_o}, 32'd0);
      else begin
        e = q_wd.pop_front();
        check("wdone_cycle", cyc, e.due);
      end
    end
    if (err_o) begin
      if (q_err.size() == 0) check("err_unexpected", {31'b0, err_o}, 32'd0);
      else begin
        e = q_err.pop_front();
        check("err_cycle", cyc, e.due);
      end
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ready_o) check("ready_timeout", {31'b0, ready_o}, 32'd1);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    wait_ready();
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    model[a] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [AW+1:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input bit use_exp);
    logic [AW-1:0] wa;
    logic [31:0]   res;
    bit            bad;
    wait_ready();
    if (!ready_o) return;
    wa  = a[AW+1:2];
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    res = 32'd0;
    if (bad) begin
      q_err.push_back(mk(32'd0, '0, cyc + 1));
    end else if (!we) begin
      res = use_exp ? exp : ld_ext(model[wa], sz, uns, a);
      q_ren.push_back(mk(32'd0, wa, cyc + 1));
      q_rd.push_back(mk(res, '0, cyc + 3));
    end else begin
      res = st_merge(model[wa], sz, a, wd);
      model[wa] = res;
      if (use_exp) res = exp;
      if (sz == 2'b10) begin
        q_wr.push_back(mk(res, wa, cyc + 1));
        q_wd.push_back(mk(32'd0, '0, cyc + 2));
      end else begin
        q_ren.push_back(mk(32'd0, wa, cyc + 1));
        q_wr.push_back(mk(res, wa, cyc + 2));
        q_wd.push_back(mk(32'd0, '0, cyc + 3));
      end
    end
    $display("tx cyc=%0d we=%0d size=%0d uns=%0d addr=0x%04h wdata=0x%08h expect=0x%08h%s",
             cyc, we, sz, uns, a, wd, res, bad ? " (error)" : "");
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    @(posedge clk);
    #1 req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_flags", {26'b0, ready_o, rvalid_o, wdone_o, err_o, ram_ren_o, ram_wen_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_wdata", ram_wdata_o, 32'd0);
    #1 rst = 1'b1;

    for (int i = 0; i < 8; i++) preload(AW'(i), $urandom);

    // Word store then word load, back to back
    issue(1'b1, 2'b10, 1'b0, 14'h010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'd0, 32'hDEAD_BEEF, 1'b1);

    // Byte store read-modify-write
    preload(AW'(4), 32'h1122_3344);
    issue(1'b1, 2'b00, 1'b0, 14'h013, 32'h0000_005A, 32'h5A22_3344, 1'b1);

    // Byte loads, signed and unsigned
    preload(AW'(4), 32'h8A22_3344);
    issue(1'b0, 2'b00, 1'b0, 14'h013, 32'd0, 32'hFFFF_FF8A, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 14'h013, 32'd0, 32'h0000_008A, 1'b1);

    // Half load signed, half store lower lane
    preload(AW'(4), 32'h8001_7FFF);
    issue(1'b0, 2'b01, 1'b0, 14'h012, 32'd0, 32'hFFFF_8001, 1'b1);
    issue(1'b1, 2'b01, 1'b0, 14'h010, 32'h0000_BEEF, 32'h8001_BEEF, 1'b1);

    // Misaligned and illegal requests
    issue(1'b0, 2'b01, 1'b0, 14'h011, 32'd0, 32'd0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 14'h012, 32'd0, 32'd0, 1'b0);
    issue(1'b1, 2'b11, 1'b0, 14'h010, 32'h1234_5678, 32'd0, 1'b0);

    // Reset during the read phase of a byte store aborts it
    wait_ready();
    q_ren.push_back(mk(32'd0, AW'(4), cyc + 1));
    $display("tx cyc=%0d byte store 0xA5 @0x0013 to be aborted by reset", cyc);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; unsigned_i = 1'b0; addr_i = 14'h013; wdata_i = 32'hA5;
    @(posedge clk);
    #1 req_i = 1'b0;
    @(negedge clk);
    check("abort_in_rd", {31'b0, ram_ren_o}, 32'd1);
    #1 rst = 1'b0;
    #1 check("abort_flags", {26'b0, ready_o, rvalid_o, wdone_o, err_o, ram_ren_o, ram_wen_o}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("ready_after_rst", {31'b0, ready_o}, 32'd1);
    repeat (4) @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'd0, 32'h8001_BEEF, 1'b1);

    // Random mix over a small address window
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            14'($urandom_range(0, 31)), $urandom, 32'd0, 1'b0);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained",
          32'(q_rd.size() + q_ren.size() + q_wr.size() + q_wd.size() + q_err.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
